// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the core_l0 memory-port arbiter.
// Contents:
//   owner_e      - which requester owns the outstanding transaction
//   arb_state_e  - arbiter FSM states
//   GNT_IF/GNT_LS- bit positions inside the one-hot grant vector
//   *_DEF        - default parameter values
package core_l0_pkg;

    localparam int unsigned ADDR_W_DEF     = 32;
    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned STARVE_MAX_DEF = 4;

    localparam int unsigned GNT_IF = 0;
    localparam int unsigned GNT_LS = 1;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of every handshake/bus signal around mem_port_arbiter.
//   if_req_* / if_rsp_*  instruction-fetch request (read-only) and response
//   ls_req_* / ls_rsp_*  load/store request and completion
//   mem_*                single unified memory port
//   busy                 transaction outstanding
// Modports:
//   slave  - the arbiter's view (takes requests and memory completions)
//   master - the surrounding core/memory view
interface mem_port_arbiter_if
    import core_l0_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic                  if_req_valid;
    logic                  if_req_ready;
    logic [ADDR_W-1:0]     if_req_addr;
    logic                  if_rsp_valid;
    logic [DATA_W-1:0]     if_rsp_rdata;

    logic                  ls_req_valid;
    logic                  ls_req_ready;
    logic [ADDR_W-1:0]     ls_req_addr;
    logic                  ls_req_we;
    logic [DATA_W-1:0]     ls_req_wdata;
    logic [DATA_W/8-1:0]   ls_req_wstrb;
    logic                  ls_rsp_valid;
    logic [DATA_W-1:0]     ls_rsp_rdata;

    logic                  mem_req;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_we;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  busy;

    modport slave (
        input  if_req_valid, if_req_addr,
        input  ls_req_valid, ls_req_addr, ls_req_we, ls_req_wdata, ls_req_wstrb,
        input  mem_rvalid, mem_rdata,
        output if_req_ready, if_rsp_valid, if_rsp_rdata,
        output ls_req_ready, ls_rsp_valid, ls_rsp_rdata,
        output mem_req, mem_addr, mem_we, mem_wdata, mem_wstrb,
        output busy
    );

    modport master (
        output if_req_valid, if_req_addr,
        output ls_req_valid, ls_req_addr, ls_req_we, ls_req_wdata, ls_req_wstrb,
        output mem_rvalid, mem_rdata,
        input  if_req_ready, if_rsp_valid, if_rsp_rdata,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_rdata,
        input  mem_req, mem_addr, mem_we, mem_wdata, mem_wstrb,
        input  busy
    );

endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// arb_pick: combinational two-way pick between IF and LS.
// Ports:
//   if_valid, ls_valid  request valids
//   starve              IF has lost STARVE_MAX times in a row (default build)
//   last_owner          owner of the previous grant (round-robin build)
//   grant[1:0]          one-hot grant, bit GNT_IF / GNT_LS; zero when idle
// Macro MEM_PORT_ARBITER_RR_EN selects round-robin instead of LS priority
// with starvation override.
module arb_pick
    import core_l0_pkg::*;
(
    input  logic       if_valid,
    input  logic       ls_valid,
`ifdef MEM_PORT_ARBITER_RR_EN
    input  owner_e     last_owner,
`else
    input  logic       starve,
`endif
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
`ifdef MEM_PORT_ARBITER_RR_EN
        if (if_valid && ls_valid) begin
            // On conflict the side that did not win last time goes first.
            if (last_owner == OWN_LS) grant[GNT_IF] = 1'b1;
            else                      grant[GNT_LS] = 1'b1;
        end else begin
            grant[GNT_IF] = if_valid;
            grant[GNT_LS] = ls_valid;
        end
`else
        if (ls_valid && !(starve && if_valid)) grant[GNT_LS] = 1'b1;
        else if (if_valid)                     grant[GNT_IF] = 1'b1;
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the core_l0 unified memory port between the
// instruction-fetch (IF) and load/store (LS) requesters, one transaction
// outstanding at a time, routing each completion back to its issuer.
// Ports:
//   clk    core clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mem_port_arbiter_if.slave: IF/LS request+response, memory port, busy
// Macro MEM_PORT_ARBITER_RR_EN: round-robin arbitration (no starvation counter).
module mem_port_arbiter
    import core_l0_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned STRB_W = DATA_W / 8;

    arb_state_e          state;
    owner_e              owner;
    logic [1:0]          grant;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [STRB_W-1:0]   mem_wstrb_q;
    logic                busy_q;
    logic                if_rsp_valid_q;
    logic                ls_rsp_valid_q;
    logic [DATA_W-1:0]   if_rsp_rdata_q;
    logic [DATA_W-1:0]   ls_rsp_rdata_q;
    logic                arb_open;

`ifdef MEM_PORT_ARBITER_RR_EN
    owner_e last_owner;

    arb_pick u_arb_pick (
        .if_valid   (bus.if_req_valid),
        .ls_valid   (bus.ls_req_valid),
        .last_owner (last_owner),
        .grant      (grant)
    );
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;
    logic       starve;

    assign starve = (starve_cnt == STARVE_LIM);

    arb_pick u_arb_pick (
        .if_valid (bus.if_req_valid),
        .ls_valid (bus.ls_req_valid),
        .starve   (starve),
        .grant    (grant)
    );
`endif

    // Arbitration only while idle and out of reset; ready is the grant itself.
    assign arb_open         = rst_n && (state == ARB_IDLE);
    assign bus.if_req_ready = arb_open && grant[GNT_IF];
    assign bus.ls_req_ready = arb_open && grant[GNT_LS];

    assign bus.mem_req      = mem_req_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.mem_wstrb    = mem_wstrb_q;
    assign bus.busy         = busy_q;
    assign bus.if_rsp_valid = if_rsp_valid_q;
    assign bus.if_rsp_rdata = if_rsp_rdata_q;
    assign bus.ls_rsp_valid = ls_rsp_valid_q;
    assign bus.ls_rsp_rdata = ls_rsp_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ARB_IDLE;
            owner          <= OWN_IF;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_wstrb_q    <= '0;
            busy_q         <= 1'b0;
            if_rsp_valid_q <= 1'b0;
            ls_rsp_valid_q <= 1'b0;
            if_rsp_rdata_q <= '0;
            ls_rsp_rdata_q <= '0;
`ifdef MEM_PORT_ARBITER_RR_EN
            last_owner     <= OWN_IF;
`else
            starve_cnt     <= '0;
`endif
        end else begin
            mem_req_q      <= 1'b0;
            if_rsp_valid_q <= 1'b0;
            ls_rsp_valid_q <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant[GNT_LS]) begin
                        mem_addr_q  <= bus.ls_req_addr;
                        mem_we_q    <= bus.ls_req_we;
                        mem_wdata_q <= bus.ls_req_wdata;
                        mem_wstrb_q <= bus.ls_req_wstrb;
                        mem_req_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        owner       <= OWN_LS;
                        state       <= ARB_WAIT;
`ifdef MEM_PORT_ARBITER_RR_EN
                        last_owner  <= OWN_LS;
`else
                        // Only count losses that IF actually suffered.
                        if (bus.if_req_valid && !starve)
                            starve_cnt <= starve_cnt + 4'd1;
`endif
                    end else if (grant[GNT_IF]) begin
                        mem_addr_q  <= bus.if_req_addr;
                        mem_we_q    <= 1'b0;
                        mem_wdata_q <= '0;
                        mem_wstrb_q <= '0;
                        mem_req_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        owner       <= OWN_IF;
                        state       <= ARB_WAIT;
`ifdef MEM_PORT_ARBITER_RR_EN
                        last_owner  <= OWN_IF;
`else
                        starve_cnt  <= '0;
`endif
                    end
`ifndef SYNTHESIS
                    if (bus.mem_rvalid)
                        $warning("mem_port_arbiter: mem_rvalid with nothing outstanding, ignored");
`endif
                end
                ARB_WAIT: begin
                    if (bus.mem_rvalid) begin
                        state  <= ARB_IDLE;
                        busy_q <= 1'b0;
                        if (owner == OWN_IF) begin
                            if_rsp_valid_q <= 1'b1;
                            if_rsp_rdata_q <= bus.mem_rdata;
                        end else begin
                            ls_rsp_valid_q <= 1'b1;
                            // mem_we_q still describes the outstanding transaction.
                            ls_rsp_rdata_q <= mem_we_q ? '0 : bus.mem_rdata;
                        end
                    end
                end
            endcase
        end
    end

endmodule
